// File: rtl/complex_mxv_stream_engine.sv
// Streaming complex matrix-vector engine: one complex dot product per row,
// UNITS lanes per beat, three-stage product/tree/accumulate pipeline.

module complex_mxv_lane #(
    parameter int ELEM_W = 64,
    parameter int PW     = 2 * (ELEM_W / 2) + 1
) (
    input  logic              clk,
    input  logic              en,
    input  logic              lane_en,
    input  logic              conj,
    input  logic [ELEM_W-1:0] a,
    input  logic [ELEM_W-1:0] b,
    output logic [PW-1:0]     p_re,
    output logic [PW-1:0]     p_im
);
    localparam int HW = ELEM_W / 2;

    logic signed [PW-1:0] ar, ai, br, bi, rr, ii, ri, ir;

    // Masked lanes are zeroed ahead of the multipliers so their junk never reaches the sum.
    always_comb begin
        ar = lane_en ? PW'($signed(a[ELEM_W-1:HW])) : '0;
        ai = lane_en ? PW'($signed(a[HW-1:0]))      : '0;
        br = lane_en ? PW'($signed(b[ELEM_W-1:HW])) : '0;
        bi = lane_en ? PW'($signed(b[HW-1:0]))      : '0;
        rr = ar * br;
        ii = ai * bi;
        ri = ar * bi;
        ir = ai * br;
    end

    always_ff @(posedge clk) begin
        if (en) begin
            p_re <= conj ? rr + ii : rr - ii;
            p_im <= conj ? ri - ir : ri + ir;
        end
    end
endmodule

module complex_mxv_stream_engine #(
    parameter int ELEM_W = 64,
    parameter int UNITS  = 8,
    parameter int LEN_W  = 16,
    parameter int ADDR_W = 8,
    parameter int FRAC   = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         num_rows,
    input  logic [LEN_W-1:0]          row_len,
    input  logic                      conj_en,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [UNITS*ELEM_W-1:0]   vec_a,
    input  logic [UNITS*ELEM_W-1:0]   vec_b,
    output logic [ELEM_W-1:0]         result,
    output logic                      result_we,
    output logic [ADDR_W-1:0]         result_addr,
    output logic                      busy,
    output logic                      done
);
    localparam int HW = ELEM_W / 2;
    localparam int PW = 2 * HW + 1;
    localparam int SW = PW + $clog2(UNITS) + 1;
    localparam int AW = SW + LEN_W;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    typedef struct packed {
        logic              last;
        logic [ADDR_W-1:0] row;
    } tag_t;

    state_t state, state_nx;
    logic [ADDR_W-1:0] rows_q, row_cnt;
    logic [LEN_W-1:0]  bpr_q, rem_q, beat_cnt, bpr_calc, rem_calc;
    logic              conj_q, accept, last_beat, last_row;
    logic [UNITS-1:0]  lane_en;
    logic [UNITS-1:0][PW-1:0] p_re, p_im;
    logic [2:1]        vld_pipe;
    tag_t              tag1, tag2;
    logic signed [SW-1:0] tree_re, tree_im, sum_re, sum_im;
    logic signed [AW-1:0] acc_re, acc_im, acc_re_nx, acc_im_nx;

    assign in_ready  = (state == RUN);
    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last_beat = (beat_cnt == bpr_q - LEN_W'(1));
    assign last_row  = (row_cnt == rows_q - ADDR_W'(1));

    always_comb begin
        bpr_calc = LEN_W'((int'(row_len) + UNITS - 1) / UNITS);
        rem_calc = LEN_W'(int'(row_len) - (int'(bpr_calc) - 1) * UNITS);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = (num_rows == '0 || row_len == '0) ? DONE : RUN;
            RUN:   if (accept && last_beat && last_row) state_nx = DRAIN;
            // Final write is the last thing in flight once both earlier stages are empty.
            DRAIN: if (result_we && vld_pipe == '0) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rows_q   <= '0;
            bpr_q    <= '0;
            rem_q    <= '0;
            conj_q   <= 1'b0;
            beat_cnt <= '0;
            row_cnt  <= '0;
        end else if (state == IDLE && start) begin
            rows_q   <= num_rows;
            bpr_q    <= bpr_calc;
            rem_q    <= rem_calc;
            conj_q   <= conj_en;
            beat_cnt <= '0;
            row_cnt  <= '0;
        end else if (accept) begin
            if (last_beat) begin
                beat_cnt <= '0;
                row_cnt  <= row_cnt + ADDR_W'(1);
            end else begin
                beat_cnt <= beat_cnt + LEN_W'(1);
            end
        end
    end

    for (genvar k = 0; k < UNITS; k++) begin : g_lane
        assign lane_en[k] = !last_beat || (LEN_W'(k) < rem_q);
        complex_mxv_lane #(.ELEM_W(ELEM_W), .PW(PW)) u_lane (
            .clk     (clk),
            .en      (accept),
            .lane_en (lane_en[k]),
            .conj    (conj_q),
            .a       (vec_a[k*ELEM_W +: ELEM_W]),
            .b       (vec_b[k*ELEM_W +: ELEM_W]),
            .p_re    (p_re[k]),
            .p_im    (p_im[k])
        );
    end

    always_comb begin
        tree_re = '0;
        tree_im = '0;
        for (int k = 0; k < UNITS; k++) begin
            tree_re = tree_re + SW'($signed(p_re[k]));
            tree_im = tree_im + SW'($signed(p_im[k]));
        end
        acc_re_nx = acc_re + AW'(sum_re);
        acc_im_nx = acc_im + AW'(sum_im);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            tag1     <= '0;
            tag2     <= '0;
        end else begin
            vld_pipe <= {vld_pipe[1], accept};
            if (accept) tag1 <= '{last: last_beat, row: row_cnt};
            tag2 <= tag1;
        end
    end

    always_ff @(posedge clk) begin
        if (vld_pipe[1]) begin
            sum_re <= tree_re;
            sum_im <= tree_im;
        end
    end

    // Closing a row writes acc+sum and clears, so the next row's first beat lands on zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_re      <= '0;
            acc_im      <= '0;
            result      <= '0;
            result_we   <= 1'b0;
            result_addr <= '0;
        end else begin
            result_we <= 1'b0;
            if (vld_pipe[2]) begin
                if (tag2.last) begin
                    acc_re      <= '0;
                    acc_im      <= '0;
                    result      <= {HW'(acc_re_nx >>> FRAC), HW'(acc_im_nx >>> FRAC)};
                    result_we   <= 1'b1;
                    result_addr <= tag2.row;
                end else begin
                    acc_re <= acc_re_nx;
                    acc_im <= acc_im_nx;
                end
            end
        end
    end
endmodule

// File: tb/tb_complex_mxv_stream_engine.sv
// Directed + randomized bench for complex_mxv_stream_engine with a plain-arithmetic model.

module tb_complex_mxv_stream_engine;
    localparam int ELEM_W = 64;
    localparam int UNITS  = 8;
    localparam int LEN_W  = 16;
    localparam int ADDR_W = 8;
    localparam int BW     = UNITS * ELEM_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] num_rows = '0;
    logic [LEN_W-1:0]  row_len = '0;
    logic              conj_en = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [BW-1:0]     vec_a = '0;
    logic [BW-1:0]     vec_b = '0;
    logic [ELEM_W-1:0] result;
    logic              result_we;
    logic [ADDR_W-1:0] result_addr;
    logic              busy;
    logic              done;

    complex_mxv_stream_engine #(.ELEM_W(ELEM_W), .UNITS(UNITS), .LEN_W(LEN_W),
                                .ADDR_W(ADDR_W), .FRAC(0)) dut (
        .clk(clk), .reset(reset), .start(start), .num_rows(num_rows),
        .row_len(row_len), .conj_en(conj_en), .in_valid(in_valid),
        .in_ready(in_ready), .vec_a(vec_a), .vec_b(vec_b), .result(result),
        .result_we(result_we), .result_addr(result_addr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] re;
        logic [31:0] im;
        logic [7:0]  addr;
        int          cyc;
        logic        busy;
    } wr_t;

    wr_t  wq[$];
    int   dcyc[$];
    logic dbusy[$];

    always @(negedge clk) begin
        if (result_we) wq.push_back('{result[63:32], result[31:0], result_addr, cyc, busy});
        if (done) begin
            dcyc.push_back(cyc);
            dbusy.push_back(busy);
        end
    end

    int ntests = 0;
    int nfail  = 0;
    int g_first, g_last;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // pat 0: a=1+j2 b=3+j4; 1: a=b=1+j1; 2: a=(r+1)+j0 b=1; 3: random 20-bit signed
    function automatic void elem(input int pat, input int r, output int ar, output int ai,
                                 output int br, output int bi);
        case (pat)
            0: begin ar = 1; ai = 2; br = 3; bi = 4; end
            1: begin ar = 1; ai = 1; br = 1; bi = 1; end
            2: begin ar = r + 1; ai = 0; br = 1; bi = 0; end
            default: begin
                ar = int'($urandom_range(0, 1048575)) - 524288;
                ai = int'($urandom_range(0, 1048575)) - 524288;
                br = int'($urandom_range(0, 1048575)) - 524288;
                bi = int'($urandom_range(0, 1048575)) - 524288;
            end
        endcase
    endfunction

    task automatic run_job(input string name, input int rows, input int len, input bit cj,
                           input int pat, input int gap);
        logic [BW-1:0] a, b;
        longint sre[4], sim[4];
        logic [31:0] er, ei, lr, li;
        int bpr, t, ar, ai, br, bi, n;
        wq.delete(); dcyc.delete(); dbusy.delete();
        bpr = (len + UNITS - 1) / UNITS;
        @(negedge clk);
        start = 1'b1; num_rows = ADDR_W'(rows); row_len = LEN_W'(len); conj_en = cj;
        @(negedge clk);
        start = 1'b0;
        for (int r = 0; r < rows; r++) begin
            sre[r] = 0; sim[r] = 0;
            for (int bt = 0; bt < bpr; bt++) begin
                for (int k = 0; k < UNITS; k++) begin
                    if (bt * UNITS + k < len) begin
                        elem(pat, r, ar, ai, br, bi);
                        if (cj) begin
                            sre[r] += longint'(ar) * br + longint'(ai) * bi;
                            sim[r] += longint'(ar) * bi - longint'(ai) * br;
                        end else begin
                            sre[r] += longint'(ar) * br - longint'(ai) * bi;
                            sim[r] += longint'(ar) * bi + longint'(ai) * br;
                        end
                        a[k*ELEM_W +: ELEM_W] = {ar, ai};
                        b[k*ELEM_W +: ELEM_W] = {br, bi};
                    end else begin
                        a[k*ELEM_W +: ELEM_W] = {$urandom, $urandom};
                        b[k*ELEM_W +: ELEM_W] = {$urandom, $urandom};
                    end
                end
                if (gap > 0 && !(r == 0 && bt == 0)) begin
                    in_valid = 1'b0;
                    repeat (gap) @(negedge clk);
                end
                in_valid = 1'b1; vec_a = a; vec_b = b;
                t = 0;
                while (!in_ready && t < 50) begin @(negedge clk); t++; end
                if (t >= 50) check({name, "_ready_timeout"}, 64'(t), 0);
                if (r == 0 && bt == 0) g_first = cyc;
                g_last = cyc;
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        t = 0;
        while (dcyc.size() == 0 && t < 100) begin @(negedge clk); t++; end
        @(negedge clk);
        check({name, "_done_count"}, 64'(dcyc.size()), 1);
        check({name, "_we_count"}, 64'(wq.size()), 64'(rows));
        n = (wq.size() < rows) ? wq.size() : rows;
        for (int r = 0; r < n; r++) begin
            er = 32'(sre[r]); ei = 32'(sim[r]);
            lr = wq[r].re; li = wq[r].im;
            check({name, "_re"}, 64'(lr), 64'(er));
            check({name, "_im"}, 64'(li), 64'(ei));
            check({name, "_addr"}, 64'(wq[r].addr), 64'(r));
        end
        if (n > 0) begin
            check({name, "_we_latency"}, 64'(wq[n-1].cyc), 64'(g_last + 3));
            check({name, "_busy_at_we"}, 64'(wq[n-1].busy), 1);
            if (dcyc.size() > 0) begin
                check({name, "_done_after_we"}, 64'(dcyc[0]), 64'(wq[n-1].cyc + 1));
                check({name, "_busy_at_done"}, 64'(dbusy[0]), 0);
            end
        end
    endtask

    initial begin
        int c0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 0);
        check("rst_result", result, 0);
        check("rst_result_we", 64'(result_we), 0);
        check("rst_result_addr", 64'(result_addr), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);

        run_job("dot", 1, 16, 1'b0, 0, 0);
        check("dot_beat_span", 64'(g_last - g_first), 1);

        run_job("partial", 1, 5, 1'b0, 1, 0);
        run_job("conj", 1, 8, 1'b1, 0, 0);

        run_job("b2b", 3, 16, 1'b0, 2, 0);
        check("b2b_ready_run", 64'(g_last - g_first), 5);
        if (wq.size() == 3) begin
            check("b2b_spacing01", 64'(wq[1].cyc - wq[0].cyc), 2);
            check("b2b_spacing12", 64'(wq[2].cyc - wq[1].cyc), 2);
        end

        run_job("gap", 1, 16, 1'b0, 0, 3);

        // Abort mid-job after the first of two beats
        wq.delete(); dcyc.delete(); dbusy.delete();
        @(negedge clk);
        start = 1'b1; num_rows = 8'd1; row_len = 16'd16; conj_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1;
        vec_a = {UNITS{32'd1, 32'd2}};
        vec_b = {UNITS{32'd3, 32'd4}};
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_we_count", 64'(wq.size()), 0);
        check("abort_done_count", 64'(dcyc.size()), 0);
        check("abort_busy", 64'(busy), 0);
        check("abort_in_ready", 64'(in_ready), 0);
        run_job("after_abort", 1, 16, 1'b0, 0, 0);

        // Empty job finishes immediately with no writes
        wq.delete(); dcyc.delete(); dbusy.delete();
        @(negedge clk);
        start = 1'b1; num_rows = 8'd0; row_len = 16'd16;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("zero_done_count", 64'(dcyc.size()), 1);
        if (dcyc.size() > 0) check("zero_done_cycle", 64'(dcyc[0]), 64'(c0 + 1));
        check("zero_we_count", 64'(wq.size()), 0);

        for (int i = 0; i < 5; i++)
            run_job("rand", int'($urandom_range(1, 4)), int'($urandom_range(1, 20)),
                    1'($urandom_range(0, 1)), 3, int'($urandom_range(0, 2)));

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
